// File: rtl/swervolf_ram_gate_pkg.sv
// Shared types for the RAM gate: FSM states, status encodings and AXI responses.
package swervolf_ram_gate_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'b00,
    ST_PASS      = 2'b01,
    ST_ERR       = 2'b10
  } state_t;

  localparam logic [1:0] STATUS_WAIT_INIT = 2'b00;
  localparam logic [1:0] STATUS_PASS      = 2'b01;
  localparam logic [1:0] STATUS_ERR       = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] status_of(input state_t s);
    logic [1:0] st;
    st = STATUS_WAIT_INIT;
    case (s)
      ST_PASS: st = STATUS_PASS;
      ST_ERR:  st = STATUS_ERR;
      default: st = STATUS_WAIT_INIT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/swervolf_ram_gate_axi_err_slave.sv
// AXI error slave: answers every write with one SLVERR B and every read with
// arlen+1 zero-data SLVERR beats; one outstanding transaction per direction.
module swervolf_axi_err_slave
  import swervolf_ram_gate_pkg::*;
#(
  parameter int ID_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic                awvalid,
  output logic                awready,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [7:0]          arlen,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_WIDTH-1:0] rid,
  output logic [63:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  logic                wr_pend;
  logic                b_pend;
  logic [ID_WIDTH-1:0] wr_id;
  logic                rd_pend;
  logic [ID_WIDTH-1:0] rd_id;
  logic [7:0]          rd_len;
  logic [7:0]          beat;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign awready = en & ~wr_pend;
  assign wready  = en & wr_pend & ~b_pend;
  assign bvalid  = en & b_pend;
  assign bid     = wr_id;
  assign bresp   = RESP_SLVERR;

  assign arready = en & ~rd_pend;
  assign rvalid  = en & rd_pend;
  assign rlast   = rd_pend & (beat == rd_len);
  assign rid     = rd_id;
  assign rdata   = '0;
  assign rresp   = RESP_SLVERR;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  // Clearing whenever disabled guarantees nothing is left in flight after a reset.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      wr_pend <= 1'b0;
      b_pend  <= 1'b0;
      wr_id   <= '0;
    end else begin
      if (aw_hs) begin
        wr_pend <= 1'b1;
        wr_id   <= awid;
      end
      if (w_hs && wlast) begin
        b_pend <= 1'b1;
      end
      if (b_hs) begin
        b_pend  <= 1'b0;
        wr_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      rd_pend <= 1'b0;
      rd_id   <= '0;
      rd_len  <= '0;
      beat    <= '0;
    end else if (ar_hs) begin
      rd_pend <= 1'b1;
      rd_id   <= arid;
      rd_len  <= arlen;
      beat    <= '0;
    end else if (r_hs) begin
      if (rlast) begin
        rd_pend <= 1'b0;
      end else begin
        beat <= beat + 8'd1;
      end
    end
  end

endmodule

// File: rtl/swervolf_ram_gate.sv
// Holds the AXI path to the DDR controller closed until calibration finishes, then
// either wires slave to master combinationally or answers everything with SLVERR.
module swervolf_ram_gate
  import swervolf_ram_gate_pkg::*;
#(
  parameter int          ID_WIDTH     = 6,
  parameter logic [31:0] INIT_TIMEOUT = 32'd50_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_init_done,
  input  logic                i_init_error,
  output logic [1:0]          o_status,

  input  logic [ID_WIDTH-1:0] i_s_awid,
  input  logic [31:0]         i_s_awaddr,
  input  logic [7:0]          i_s_awlen,
  input  logic [2:0]          i_s_awsize,
  input  logic [1:0]          i_s_awburst,
  input  logic                i_s_awvalid,
  output logic                o_s_awready,
  input  logic [63:0]         i_s_wdata,
  input  logic [7:0]          i_s_wstrb,
  input  logic                i_s_wlast,
  input  logic                i_s_wvalid,
  output logic                o_s_wready,
  output logic [ID_WIDTH-1:0] o_s_bid,
  output logic [1:0]          o_s_bresp,
  output logic                o_s_bvalid,
  input  logic                i_s_bready,
  input  logic [ID_WIDTH-1:0] i_s_arid,
  input  logic [31:0]         i_s_araddr,
  input  logic [7:0]          i_s_arlen,
  input  logic [2:0]          i_s_arsize,
  input  logic [1:0]          i_s_arburst,
  input  logic                i_s_arvalid,
  output logic                o_s_arready,
  output logic [ID_WIDTH-1:0] o_s_rid,
  output logic [63:0]         o_s_rdata,
  output logic [1:0]          o_s_rresp,
  output logic                o_s_rlast,
  output logic                o_s_rvalid,
  input  logic                i_s_rready,

  output logic [ID_WIDTH-1:0] o_m_awid,
  output logic [31:0]         o_m_awaddr,
  output logic [7:0]          o_m_awlen,
  output logic [2:0]          o_m_awsize,
  output logic [1:0]          o_m_awburst,
  output logic                o_m_awvalid,
  input  logic                i_m_awready,
  output logic [63:0]         o_m_wdata,
  output logic [7:0]          o_m_wstrb,
  output logic                o_m_wlast,
  output logic                o_m_wvalid,
  input  logic                i_m_wready,
  input  logic [ID_WIDTH-1:0] i_m_bid,
  input  logic [1:0]          i_m_bresp,
  input  logic                i_m_bvalid,
  output logic                o_m_bready,
  output logic [ID_WIDTH-1:0] o_m_arid,
  output logic [31:0]         o_m_araddr,
  output logic [7:0]          o_m_arlen,
  output logic [2:0]          o_m_arsize,
  output logic [1:0]          o_m_arburst,
  output logic                o_m_arvalid,
  input  logic                i_m_arready,
  input  logic [ID_WIDTH-1:0] i_m_rid,
  input  logic [63:0]         i_m_rdata,
  input  logic [1:0]          i_m_rresp,
  input  logic                i_m_rlast,
  input  logic                i_m_rvalid,
  output logic                o_m_rready
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] cnt;
  logic        timeout_hit;
  logic        pass;
  logic        err;

  logic                e_awready, e_wready, e_bvalid, e_arready, e_rvalid, e_rlast;
  logic [ID_WIDTH-1:0] e_bid, e_rid;
  logic [1:0]          e_bresp, e_rresp;
  logic [63:0]         e_rdata;

  assign timeout_hit = (INIT_TIMEOUT != 32'd0) && (cnt == INIT_TIMEOUT - 32'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_WAIT_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT_INIT) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // Error takes priority over done; PASS and ERR only leave through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_INIT: begin
        if (i_init_error || timeout_hit) begin
          state_nxt = ST_ERR;
        end else if (i_init_done) begin
          state_nxt = ST_PASS;
        end
      end
      default: state_nxt = state;
    endcase
  end

  assign o_status = status_of(state);
  assign pass     = (state == ST_PASS);
  assign err      = (state == ST_ERR);

  swervolf_axi_err_slave #(
    .ID_WIDTH (ID_WIDTH)
  ) u_err (
    .clk     (i_clk),
    .rst     (i_rst),
    .en      (err),
    .awid    (i_s_awid),
    .awvalid (i_s_awvalid),
    .awready (e_awready),
    .wlast   (i_s_wlast),
    .wvalid  (i_s_wvalid),
    .wready  (e_wready),
    .bid     (e_bid),
    .bresp   (e_bresp),
    .bvalid  (e_bvalid),
    .bready  (i_s_bready),
    .arid    (i_s_arid),
    .arlen   (i_s_arlen),
    .arvalid (i_s_arvalid),
    .arready (e_arready),
    .rid     (e_rid),
    .rdata   (e_rdata),
    .rresp   (e_rresp),
    .rlast   (e_rlast),
    .rvalid  (e_rvalid),
    .rready  (i_s_rready)
  );

  // Payloads flow through unconditionally; only the handshake wires are gated.
  assign o_m_awid    = i_s_awid;
  assign o_m_awaddr  = i_s_awaddr;
  assign o_m_awlen   = i_s_awlen;
  assign o_m_awsize  = i_s_awsize;
  assign o_m_awburst = i_s_awburst;
  assign o_m_wdata   = i_s_wdata;
  assign o_m_wstrb   = i_s_wstrb;
  assign o_m_wlast   = i_s_wlast;
  assign o_m_arid    = i_s_arid;
  assign o_m_araddr  = i_s_araddr;
  assign o_m_arlen   = i_s_arlen;
  assign o_m_arsize  = i_s_arsize;
  assign o_m_arburst = i_s_arburst;

  assign o_m_awvalid = pass & i_s_awvalid;
  assign o_m_wvalid  = pass & i_s_wvalid;
  assign o_m_bready  = pass & i_s_bready;
  assign o_m_arvalid = pass & i_s_arvalid;
  assign o_m_rready  = pass & i_s_rready;

  assign o_s_awready = pass ? i_m_awready : (err & e_awready);
  assign o_s_wready  = pass ? i_m_wready  : (err & e_wready);
  assign o_s_bvalid  = pass ? i_m_bvalid  : (err & e_bvalid);
  assign o_s_arready = pass ? i_m_arready : (err & e_arready);
  assign o_s_rvalid  = pass ? i_m_rvalid  : (err & e_rvalid);

  assign o_s_bid   = err ? e_bid   : i_m_bid;
  assign o_s_bresp = err ? e_bresp : i_m_bresp;
  assign o_s_rid   = err ? e_rid   : i_m_rid;
  assign o_s_rdata = err ? e_rdata : i_m_rdata;
  assign o_s_rresp = err ? e_rresp : i_m_rresp;
  assign o_s_rlast = err ? e_rlast : i_m_rlast;

endmodule

// File: doc/swervolf_ram_gate.md
SWERVOLF_RAM_GATE -- requirements
Module: swervolf_ram_gate

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 6, AXI ID width on both ports.
REQ-002 SHALL have parameter INIT_TIMEOUT, default 32'd50_000_000, cycles to wait for init; 0 disables the timeout.
REQ-003 SHALL use one clock and a synchronous, active-high reset: i_clk and i_rst.
REQ-004 SHALL have i_clk  in  1  core clock; all logic on its rising edge.
REQ-005 SHALL have i_rst  in  1  synchronous active-high reset.
REQ-006 SHALL have i_init_done  in  1  memory controller calibration done.
REQ-007 SHALL have i_init_error  in  1  memory controller calibration failed.
REQ-008 SHALL have o_status  out  2  00 WAIT_INIT, 01 PASS, 10 ERR.
REQ-009 SHALL have slave AW: i_s_aw{id,addr,len,size,burst,valid} in ID_WIDTH/32/8/3/2/1; o_s_awready out 1.
REQ-010 SHALL have slave W: i_s_w{data,strb,last,valid} in 64/8/1/1; o_s_wready out 1.
REQ-011 SHALL have slave B: o_s_b{id,resp,valid} out ID_WIDTH/2/1; i_s_bready in 1.
REQ-012 SHALL have slave AR: i_s_ar{id,addr,len,size,burst,valid} in ID_WIDTH/32/8/3/2/1; o_s_arready out 1.
REQ-013 SHALL have slave R: o_s_r{id,data,resp,last,valid} out ID_WIDTH/64/2/1/1; i_s_rready in 1.
REQ-014 SHALL have master port o_m_*/i_m_* mirroring REQ-009..013 with directions reversed.

Function
REQ-015 SHALL implement three states: WAIT_INIT, PASS, ERR.
REQ-016 In WAIT_INIT: all s-side ready/valid and m-side valid/ready outputs 0; the 32-bit timeout counter increments each cycle.
REQ-017 WAIT_INIT->ERR when i_init_error=1, or when INIT_TIMEOUT!=0 and counter==INIT_TIMEOUT-1; ERR wins if i_init_done and i_init_error are high in the same cycle.
REQ-018 WAIT_INIT->PASS when i_init_done=1 and i_init_error=0.
REQ-019 PASS and ERR SHALL be terminal until i_rst; i_init_error rising after PASS is ignored.
REQ-020 In PASS: all five channels combinationally connected s<->m, zero added latency, no buffering.
REQ-021 In ERR: m-side valid/ready outputs all 0; the block itself acts as an error slave.
REQ-022 ERR write path: o_s_awready=1 only while no write is pending; the AW handshake latches awid and sets write-pending.
REQ-023 ERR write path: o_s_wready=1 only while write-pending and B not yet issued; W data is discarded; wready is first high the cycle after the AW handshake.
REQ-024 ERR write path: the W handshake with wlast=1 SHALL assert o_s_bvalid next cycle, bresp=2'b10, bid=latched id, held until i_s_bready; that B handshake clears write-pending.
REQ-025 ERR read path: o_s_arready=1 only while no read is pending; the AR handshake latches arid and arlen and zeroes the beat counter.
REQ-026 ERR read path: o_s_rvalid SHALL rise the cycle after the AR handshake and emit arlen+1 beats: rdata=0, rresp=2'b10, rid=latched id, rlast on beat arlen.
REQ-027 ERR read path: the beat counter advances only on an rvalid&rready handshake; read-pending clears on the rlast handshake; arlen=255 yields 256 beats.
REQ-028 ERR read and write paths SHALL be independent and operate concurrently, with at most one outstanding transaction each.
REQ-029 W beats arriving before AW in ERR SHALL be stalled (wready=0), never dropped.

Reset
REQ-030 On i_rst: state=WAIT_INIT, counter=0, pending flags=0, o_status=00, all s-side valid/ready=0, all m-side valid/ready=0.
REQ-031 Reset mid-burst SHALL abort any in-flight error response with no further beats or B responses emitted.

Structure
REQ-032 Package swervolf_ram_gate_pkg SHALL hold the state enum, the status encodings, and RESP_OKAY=2'b00 / RESP_SLVERR=2'b10.
REQ-033 The ERR responder SHALL be a sub-module swervolf_axi_err_slave, instantiated once and enabled by state==ERR.

Verification
REQ-034 Assert i_init_done at cycle 10 -> o_status=01 at cycle 11; AR id=5, len=3 passes through unchanged; 4 master R beats reach the slave with identical data.
REQ-035 Assert i_init_error at cycle 10 -> o_status=10; AR id=7, len=0 -> single R beat one cycle later, rresp=10, rlast=1, rid=7.
REQ-036 ERR, AW id=3, len=1, then 2 W beats (last on 2nd) -> bvalid the cycle after the 2nd beat, bresp=10, bid=3; with bready=0 for 5 cycles, B stays stable.
REQ-037 INIT_TIMEOUT=100, no init signals -> o_status switches 00->10 exactly 100 cycles after reset release; i_init_done and i_init_error both high together -> ERR.
REQ-038 ERR, AR len=255 with random rready plus a concurrent write -> exactly 256 R beats, rlast only on the last, B correct; i_rst asserted mid-burst -> outputs return to 0 on the next cycle.
